banked_ram: RTL and testbench

BANKED_RAM -- requirements
Module: banked_ram

---
 rtl/banked_ram_pkg.sv | 19 +
 rtl/banked_ram_ram_bank.sv | 25 ++
 rtl/banked_ram.sv | 117 +++++++++++
 tb/tb_banked_ram.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/banked_ram_pkg.sv
// Shared definitions for the banked RAM: default geometry, address-width
// derivation and the controller state encoding.
package banked_ram_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int BANK_AW_DEF   = 8;
  localparam int NUM_BANKS_DEF = 16;

  // Full word-address width: the in-bank word bits plus the bank-select bits.
  function automatic int calc_addr_w(input int bank_aw, input int num_banks);
    return bank_aw + $clog2(num_banks);
  endfunction

  typedef enum logic {
    SCRUB = 1'b0,
    IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/banked_ram_ram_bank.sv
// One memory bank: synchronous write with enable, combinational read.
module ram_bank #(
  parameter int DATA_W = 16,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  // Store the write word on the rising edge when enabled.
  // NOTE: the array has no reset branch on purpose; a reset of every word
  // cannot map onto RAM macros, so zeroing is done by the controller's scrub.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/banked_ram.sv
// Banked RAM top: scrub/idle controller, one-hot bank write decode,
// read mux and registered read output.
module banked_ram
  import banked_ram_pkg::*;
#(
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int BANK_AW   = BANK_AW_DEF,
  parameter  int NUM_BANKS = NUM_BANKS_DEF,
  localparam int ADDR_W    = calc_addr_w(BANK_AW, NUM_BANKS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] in,
  input  logic              load,
  input  logic              rd_en,
  input  logic              clear,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              busy
);

  localparam int BANK_SEL_W = $clog2(NUM_BANKS);

  state_t               state_q, state_d;
  logic [BANK_AW-1:0]   scrub_cnt_q, scrub_cnt_d;
  logic                 scrub_we;
  logic                 host_we;
  logic                 host_rd;

  logic [BANK_SEL_W-1:0] bank_sel;
  logic [BANK_AW-1:0]    word_sel;
  logic [NUM_BANKS-1:0]  bank_we;
  logic [BANK_AW-1:0]    bank_waddr;
  logic [DATA_W-1:0]     bank_wdata;
  logic [DATA_W-1:0]     rd_data [NUM_BANKS];

  assign bank_sel = address[ADDR_W-1:BANK_AW];
  assign word_sel = address[BANK_AW-1:0];
  assign busy     = (state_q == SCRUB);

  // Next-state logic: scrub sweeps every word once, idle serves host traffic.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    scrub_cnt_d = scrub_cnt_q;
    scrub_we    = 1'b0;
    host_we     = 1'b0;
    host_rd     = 1'b0;
    unique case (state_q)
      SCRUB: begin
        scrub_we    = 1'b1;
        scrub_cnt_d = scrub_cnt_q + 1'b1;
        if (scrub_cnt_q == '1) state_d = IDLE;
      end
      IDLE: begin
        if (clear) begin
          state_d     = SCRUB;
          scrub_cnt_d = '0;
        end else begin
          host_we = load;
          host_rd = rd_en;
        end
      end
    endcase
  end

  // Write decode: scrub hits every bank, a host write only the addressed one.
  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      bank_we[i] = scrub_we | (host_we & (bank_sel == BANK_SEL_W'(i)));
    end
  end

  assign bank_waddr = scrub_we ? scrub_cnt_q : word_sel;
  assign bank_wdata = scrub_we ? '0 : in;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    ram_bank #(
      .DATA_W (DATA_W),
      .AW     (BANK_AW)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[b]),
      .waddr (bank_waddr),
      .wdata (bank_wdata),
      .raddr (word_sel),
      .rdata (rd_data[b])
    );
  end

  // Controller state and scrub counter; reset restarts the scrub from word 0.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SCRUB;
      scrub_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      scrub_cnt_q <= scrub_cnt_d;
    end
  end

  // Registered read port: capture the old word on an accepted read, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= host_rd;
      if (host_rd) out <= rd_data[bank_sel];
    end
  end

endmodule

// File: tb/tb_banked_ram.sv
// Directed bench for banked_ram with default geometry (16 banks x 256 x 16).
module tb_banked_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] address;
  logic [15:0] in;
  logic        load;
  logic        rd_en;
  logic        clear;
  logic [15:0] out;
  logic        out_valid;
  logic        busy;

  int pass_cnt  = 0;
  int check_cnt = 0;

  banked_ram dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .in        (in),
    .load      (load),
    .rd_en     (rd_en),
    .clear     (clear),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    check_cnt++;
    assert (observed === expected) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load = 1'b0; rd_en = 1'b0; clear = 1'b0; in = '0; address = '0;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [15:0] d);
    address = a; in = d; load = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic do_read(input string tag, input logic [11:0] a,
                         input logic [15:0] exp_data);
    address = a; rd_en = 1'b1;
    tick();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  32'(out), 32'(exp_data));
    idle_inputs();
  endtask

  // Count edges until busy drops; also note any out_valid / nonzero out seen.
  task automatic wait_scrub(output int edges, output bit ov_seen, output bit out_nz);
    edges = 0; ov_seen = 0; out_nz = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      edges++;
      if (out_valid) ov_seen = 1;
      if (out !== 16'h0) out_nz = 1;
      if (!busy) break;
    end
  endtask

  initial begin
    int  edges;
    bit  ov_seen;
    bit  out_nz;

    idle_inputs();
    reset = 1'b1;
    repeat (3) tick();
    check("rst_busy",  32'(busy), 32'd1);
    check("rst_out",   32'(out), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);

    // Reset release: exactly 256 busy cycles, quiet outputs, reads ignored.
    reset = 1'b0;
    rd_en = 1'b1;
    wait_scrub(edges, ov_seen, out_nz);
    rd_en = 1'b0;
    check("scrub_len",   32'(edges), 32'd256);
    check("scrub_valid", 32'(ov_seen), 32'd0);
    check("scrub_out",   32'(out_nz), 32'd0);
    check("idle_busy",   32'(busy), 32'd0);

    do_read("rd_000", 12'h000, 16'h0000);
    do_read("rd_7ff", 12'h7FF, 16'h0000);
    do_read("rd_fff", 12'hFFF, 16'h0000);
    tick();
    check("valid_drop", 32'(out_valid), 32'd0);

    // Same word offset in neighbouring banks must stay independent.
    do_write(12'h1FF, 16'hA5A5);
    do_write(12'h2FF, 16'h5A5A);
    do_read("rd_1ff", 12'h1FF, 16'hA5A5);
    do_read("rd_2ff", 12'h2FF, 16'h5A5A);
    do_read("rd_3ff", 12'h3FF, 16'h0000);
    do_read("rd_0ff", 12'h0FF, 16'h0000);
    tick();
    check("out_hold", 32'(out), 32'h0000);

    // Read-during-write returns the old word.
    do_write(12'h123, 16'h1111);
    address = 12'h123; in = 16'h2222; load = 1'b1; rd_en = 1'b1;
    tick();
    check("rdw_valid", 32'(out_valid), 32'd1);
    check("rdw_old",   32'(out), 32'h1111);
    idle_inputs();
    do_read("rdw_new", 12'h123, 16'h2222);

    // Reset in the middle of a scrub restarts it.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_busy", 32'(busy), 32'd1);
    repeat (100) tick();
    reset = 1'b1;
    #1;
    check("mid_rst_out",  32'(out), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd1);
    tick();
    reset = 1'b0;
    rd_en = 1'b1; load = 1'b1; address = 12'h345; in = 16'h3333;
    wait_scrub(edges, ov_seen, out_nz);
    idle_inputs();
    check("rst2_len",   32'(edges), 32'd256);
    check("rst2_valid", 32'(ov_seen), 32'd0);
    do_read("rd_123_z", 12'h123, 16'h0000);
    do_read("rd_345_z", 12'h345, 16'h0000);

    // clear beats a simultaneous load/read; clear during scrub is ignored.
    do_write(12'h800, 16'hBEEF);
    do_read("rd_800", 12'h800, 16'hBEEF);
    clear = 1'b1; load = 1'b1; rd_en = 1'b1; address = 12'h801; in = 16'hFFFF;
    tick();
    check("clr_win_busy",  32'(busy), 32'd1);
    check("clr_win_valid", 32'(out_valid), 32'd0);
    in = 16'h7777;
    wait_scrub(edges, ov_seen, out_nz);
    idle_inputs();
    check("clr_len",   32'(edges), 32'd256);
    check("clr_valid", 32'(ov_seen), 32'd0);
    do_read("rd_800_z", 12'h800, 16'h0000);
    do_read("rd_801_z", 12'h801, 16'h0000);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
